div32_iter: RTL

- Multi-cycle 32-bit integer divider that answers the EXE stage's divide request handshake.
- It is the responder behind div.w/mod.w (SIGNED=1) and div.wu/mod.wu (SIGNED=0); one instance is built per signedness.
- It accepts dividend and divisor through a valid/ready handshake, runs a radix-2 restoring iteration one bit per cycle, and returns {quotient, remainder} with a valid strobe.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 24 ++
 rtl/div32_iter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants and FSM encoding for the iterative 32-bit divider.
package div_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = 33;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Two's-complement negate, used for operand magnitudes and result sign fix-up.
  function automatic logic [DIV_WIDTH-1:0] div_neg(input logic [DIV_WIDTH-1:0] v);
    return ~v + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract, keep or restore.
module div_step #(
  parameter int W = 33
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] dvsr_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0]   shifted;
  logic [W-1:0] diff;

  always_comb begin
    shifted = {rem_i, bit_i};
    // Only the low W bits matter for the difference: when the subtract is kept
    // the result is below the divisor and always fits.
    diff    = shifted[W-1:0] - dvsr_i;
    q_o     = (shifted >= {1'b0, dvsr_i});
    rem_o   = q_o ? diff : shifted[W-1:0];
  end

endmodule

// File: rtl/div32_iter.sv
// Multi-cycle 32-bit restoring divider with a paired valid/ready request and a result strobe.
// Optional DIV_HOLD_RESULT_EN keeps the result valid asserted until the next accepted request.
module div32_iter
  import div_pkg::*;
#(
  parameter bit SIGNED = 1'b1,
  parameter int WIDTH  = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata,
  output logic               m_axis_dout_tvalid
);

  div_state_e        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]  quo_q, quo_d;     // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH:0]    rem_q, rem_d;
  logic [WIDTH:0]    dvsr_q, dvsr_d;
  logic [WIDTH-1:0]  orig_q, orig_d;   // raw dividend, returned as remainder on divide-by-zero
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic              dz_q, dz_d;
  logic [2*WIDTH-1:0] dout_q, dout_d;
  logic              vld_q, vld_d;

  logic              accept;
  logic              dvd_neg, dvs_neg;
  logic [WIDTH-1:0]  dvd_mag;
  logic [WIDTH:0]    dvs_ext, dvs_mag;
  logic [WIDTH:0]    step_rem;
  logic              step_q;
  logic [WIDTH-1:0]  quo_fix, rem_fix;

  assign accept = (state_q == DIV_IDLE) && s_axis_dividend_tvalid && s_axis_divisor_tvalid;

  always_comb begin
    dvd_neg = SIGNED && s_axis_dividend_tdata[WIDTH-1];
    dvs_neg = SIGNED && s_axis_divisor_tdata[WIDTH-1];
    dvd_mag = dvd_neg ? div_neg(s_axis_dividend_tdata) : s_axis_dividend_tdata;
    dvs_ext = {dvs_neg, s_axis_divisor_tdata};
    dvs_mag = dvs_neg ? (~dvs_ext + {{WIDTH{1'b0}}, 1'b1}) : dvs_ext;
  end

  div_step #(.W(WIDTH + 1)) u_step (
    .rem_i  (rem_q),
    .bit_i  (quo_q[WIDTH-1]),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .q_o    (step_q)
  );

  assign quo_fix = q_neg_q ? div_neg(quo_q) : quo_q;
  assign rem_fix = r_neg_q ? div_neg(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    orig_d  = orig_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    dout_d  = dout_q;
`ifdef DIV_HOLD_RESULT_EN
    vld_d   = vld_q;
`else
    vld_d   = 1'b0;
`endif

    unique case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          state_d = DIV_CALC;
          cnt_d   = '0;
          quo_d   = dvd_mag;
          rem_d   = '0;
          dvsr_d  = dvs_mag;
          orig_d  = s_axis_dividend_tdata;
          q_neg_d = dvd_neg ^ dvs_neg;
          r_neg_d = dvd_neg;
          dz_d    = (s_axis_divisor_tdata == '0);
          vld_d   = 1'b0;
        end
      end
      DIV_CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        dout_d  = dz_q ? {DIV_ZERO_QUOT, orig_q} : {quo_fix, rem_fix};
        vld_d   = 1'b1;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      orig_q  <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      orig_q  <= orig_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
    end
  end

  assign s_axis_dividend_tready = (state_q == DIV_IDLE);
  assign s_axis_divisor_tready  = (state_q == DIV_IDLE);
  assign m_axis_dout_tdata      = dout_q;
  assign m_axis_dout_tvalid     = vld_q;

endmodule
